// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions and the transmit FSM state type.
package mmio_pkg;

  // Word offsets from the block's base address
  localparam int REG_DATA   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_CTRL   = 2;

  // STATUS register bit positions
  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_CNT_LSB  = 4;
  localparam int STAT_CNT_MSB  = 7;

  // CTRL register bit positions
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Serial frame phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is taken
// only when a pop happens in the same cycle, so the slot freed by the pop
// is reused and the count stays the same.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter. The CPU stores bytes to DATA, they
// queue in a small FIFO and the FSM shifts them out LSB first. STATUS and
// CTRL let software poll the queue or take a level interrupt when drained.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR    = 15'h7F00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic [14:0] bus_addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_sel,
  output logic        tx,
  output logic        irq
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [14:0]   offset;
  logic          hit;
  logic          wr_data;
  logic          wr_status;
  logic          wr_ctrl;
  logic          tx_en;
  logic          irq_en;
  logic          overflow;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rdata;
  logic          pop_req;
  logic          busy;
  logic [3:0]    cnt_sat;
  logic [15:0]   status_word;
  logic [15:0]   rdata_next;
  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          unused_wdata;

  // Addresses below the base wrap to large offsets, so one compare decodes
  assign offset    = bus_addr - BASE_ADDR;
  assign hit       = (offset < 15'd3);
  assign wr_data   = bus_we && hit && (offset == 15'(REG_DATA));
  assign wr_status = bus_we && hit && (offset == 15'(REG_STATUS));
  assign wr_ctrl   = bus_we && hit && (offset == 15'(REG_CTRL));

  assign unused_wdata = &{1'b0, bus_wdata[15:8]};

  assign busy = (state != IDLE);
  assign irq  = irq_en && fifo_empty && !busy;

  // A pop starts a frame from IDLE or chains one on the last stop-bit cycle
  assign pop_req = tx_en && !fifo_empty &&
                   ((state == IDLE) || ((state == STOP) && (baud_cnt == BAUD_LAST)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .wdata (bus_wdata[7:0]),
    .pop   (pop_req),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble STATUS and select read data for the addressed register
  always_comb begin
    cnt_sat = (int'(fifo_count) > 15) ? 4'hF : 4'(fifo_count);
    status_word = '0;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_OVERFLOW] = overflow;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB] = cnt_sat;
    rdata_next = '0;
    if (hit) begin
      case (offset)
        15'(REG_STATUS): rdata_next = status_word;
        15'(REG_CTRL):   rdata_next = {14'd0, irq_en, tx_en};
        default:         rdata_next = '0;
      endcase
    end
  end

  // Bus read register, CTRL bits and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= '0;
      bus_sel   <= 1'b0;
      tx_en     <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bus_rdata <= rdata_next;
      bus_sel   <= hit;
      if (wr_ctrl) begin
        tx_en  <= bus_wdata[CTRL_TX_EN];
        irq_en <= bus_wdata[CTRL_IRQ_EN];
      end
      if (wr_data && fifo_full && !pop_req) begin
        overflow <= 1'b1;
      end else if (wr_status && bus_wdata[STAT_OVERFLOW]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop_req) begin
            shift_reg <= fifo_rdata;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (pop_req) begin
              shift_reg <= fifo_rdata;
              bit_cnt   <= '0;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with 4 clocks per bit and a 4-entry FIFO.
module tb_mmio_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_we = 1'b0;
  logic [14:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic [15:0] bus_rdata;
  logic        bus_sel;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (15'h7F00),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_sel   (bus_sel),
    .tx        (tx),
    .irq       (irq)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present one bus cycle, then return the bus to an undecoded idle address
  task automatic applyStimulus(input logic we, input logic [14:0] addr, input logic [15:0] data);
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = data;
    tick();
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
  endtask

  task automatic busRead(input logic [14:0] addr, input logic [15:0] exp_data,
                         input logic exp_sel, input string tag);
    applyStimulus(1'b0, addr, 16'h0000);
    checkOutput({tag, "_rdata"}, bus_rdata, exp_data);
    checkOutput({tag, "_sel"}, {15'd0, bus_sel}, {15'd0, exp_sel});
  endtask

  // Check the serial line cycle by cycle from frame cycle 'first' to the end
  task automatic checkFrame(input logic [7:0] b, input int first);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = first; i < 10 * CPB; i++) begin
      checkOutput($sformatf("frame_%02h_c%0d_tx", b, i), {15'd0, tx}, {15'd0, f[i / CPB]});
      checkOutput($sformatf("frame_%02h_c%0d_irq", b, i), {15'd0, irq}, 16'h0000);
      tick();
    end
  endtask

  initial begin
    // Reset state and address decode boundaries
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_tx", {15'd0, tx}, 16'h0001);
    checkOutput("reset_irq", {15'd0, irq}, 16'h0000);
    busRead(15'h7F01, 16'h0002, 1'b1, "reset_status");
    busRead(15'h7F02, 16'h0000, 1'b1, "reset_ctrl");
    busRead(15'h7F00, 16'h0000, 1'b1, "data_read");
    busRead(15'h7F03, 16'h0000, 1'b0, "above_range");
    busRead(15'h7EFF, 16'h0000, 1'b0, "below_range");
    applyStimulus(1'b1, 15'h7F03, 16'hFFFF);
    busRead(15'h7F02, 16'h0000, 1'b1, "ctrl_after_undecoded_wr");

    // Single frame: tx falls two cycles after the DATA write
    $display("[TB] single frame");
    applyStimulus(1'b1, 15'h7F02, 16'h0001);
    applyStimulus(1'b1, 15'h7F00, 16'hFFA5);
    checkOutput("start_latency_n1", {15'd0, tx}, 16'h0001);
    tick();
    checkFrame(8'hA5, 0);
    busRead(15'h7F01, 16'h0002, 1'b1, "status_after_single");

    // Back-to-back frames with no idle gap
    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 15'h7F00, 16'h0055);
    applyStimulus(1'b1, 15'h7F00, 16'h00AA);
    checkFrame(8'h55, 0);
    checkFrame(8'hAA, 0);
    busRead(15'h7F01, 16'h0002, 1'b1, "status_after_b2b");

    // Overflow with transmitter disabled
    $display("[TB] overflow");
    applyStimulus(1'b1, 15'h7F02, 16'h0000);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 15'h7F00, 16'(i));
    busRead(15'h7F01, 16'h0049, 1'b1, "status_overflow");
    applyStimulus(1'b1, 15'h7F01, 16'hFFF7);
    busRead(15'h7F01, 16'h0049, 1'b1, "status_no_clear");
    applyStimulus(1'b1, 15'h7F01, 16'h0008);
    busRead(15'h7F01, 16'h0041, 1'b1, "status_cleared");

    // Push into a full FIFO in the same cycle as a pop is accepted
    applyStimulus(1'b1, 15'h7F02, 16'h0001);
    applyStimulus(1'b1, 15'h7F00, 16'h0066);
    checkOutput("push_pop_full_tx", {15'd0, tx}, 16'h0000);
    busRead(15'h7F01, 16'h0045, 1'b1, "status_push_pop_full");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busRead(15'h7F01, 16'h0002, 1'b1, "status_after_flush");

    // Interrupt around a single frame
    $display("[TB] interrupt and disable");
    applyStimulus(1'b1, 15'h7F02, 16'h0003);
    checkOutput("irq_idle_empty", {15'd0, irq}, 16'h0001);
    applyStimulus(1'b1, 15'h7F00, 16'h003C);
    checkOutput("irq_queued", {15'd0, irq}, 16'h0000);
    tick();
    checkFrame(8'h3C, 0);
    checkOutput("irq_after_stop", {15'd0, irq}, 16'h0001);
    checkOutput("tx_after_irq_frame", {15'd0, tx}, 16'h0001);

    // Clearing tx_en mid-frame finishes the frame and leaves one byte queued
    applyStimulus(1'b1, 15'h7F00, 16'h0011);
    applyStimulus(1'b1, 15'h7F00, 16'h0022);
    checkOutput("disable_start_tx", {15'd0, tx}, 16'h0000);
    applyStimulus(1'b1, 15'h7F02, 16'h0002);
    checkFrame(8'h11, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("disabled_idle_tx_%0d", i), {15'd0, tx}, 16'h0001);
      checkOutput($sformatf("disabled_idle_irq_%0d", i), {15'd0, irq}, 16'h0000);
      tick();
    end
    busRead(15'h7F01, 16'h0010, 1'b1, "status_disabled");

    // Reset during the data phase
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 15'h7F02, 16'h0001);
    tick();
    checkOutput("rst_frame_start", {15'd0, tx}, 16'h0000);
    applyStimulus(1'b1, 15'h7F00, 16'h0077);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("rst_frame_data_bit0", {15'd0, tx}, 16'h0000);
    rst = 1'b1;
    tick();
    checkOutput("rst_forces_tx_high", {15'd0, tx}, 16'h0001);
    rst = 1'b0;
    busRead(15'h7F01, 16'h0002, 1'b1, "status_after_rst");
    busRead(15'h7F02, 16'h0000, 1'b1, "ctrl_after_rst");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("post_rst_tx_%0d", i), {15'd0, tx}, 16'h0001);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
